// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator: one shared period counter, per-channel duty
// compare, shadow registers that load glitch-free at the period boundary.
//
// Counter direction
//   state    | meaning
//   DIR_UP   | counting up (edge mode always stays here)
//   DIR_DOWN | center mode, falling half of the period
module pwm_multi_ch #(
  parameter int                CH_NUM     = 4,
  parameter int                CNT_W      = 16,
  parameter int                PERIOD_DEF = 50000,
  parameter int                DUTY_DEF   = 30000,
  parameter logic [CH_NUM-1:0] INV        = '0
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              center_mode_i,
  input  logic              cfg_we_i,
  input  logic [3:0]        cfg_addr_i,
  input  logic [CNT_W-1:0]  cfg_wdata_i,
  output logic [CH_NUM-1:0] pwm_out_o,
  output logic              period_tick_o
);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

  localparam logic [CNT_W-1:0] PER_RST  = CNT_W'(PERIOD_DEF);
  localparam logic [CNT_W-1:0] DUTY_RST = CNT_W'(DUTY_DEF);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0]             per_sh_q, per_sh_d, per_q, per_d;
  logic [CH_NUM-1:0][CNT_W-1:0] duty_sh_q, duty_sh_d, duty_q, duty_d;
  logic                         center_q, center_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  dir_e                         dir_q, dir_d;
  logic [CH_NUM-1:0]            pwm_q, pwm_d;
  logic                         start_q, start_d;
  logic                         tick_q, tick_d;

  logic             per_zero, boundary, load, run;
  logic [CNT_W-1:0] per_last;

  // Shadow register writes; addresses beyond the last channel fall through.
  always_comb begin
    per_sh_d  = per_sh_q;
    duty_sh_d = duty_sh_q;
    if (cfg_we_i) begin
      if (cfg_addr_i == 4'd0) per_sh_d = cfg_wdata_i;
      for (int i = 0; i < CH_NUM; i++) begin
        if (cfg_addr_i == 4'(i + 1)) duty_sh_d[i] = cfg_wdata_i;
      end
    end
  end

  // Counter sequencing, boundary detection and active-register load.
  always_comb begin
    per_zero = (per_q == '0);
    per_last = per_q - ONE;
    boundary = !per_zero &&
               (center_q ? (dir_q == DIR_DOWN && cnt_q == '0) : (cnt_q == per_last));
    // Idle or zero-period keeps the active set tracking the shadow set every cycle.
    load     = !en_i || per_zero || boundary;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    if (load) begin
      // Every period (and every mode switch) restarts from 0 counting up.
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (!center_q || dir_q == DIR_UP) begin
      if (center_q && cnt_q == per_last) dir_d = DIR_DOWN;
      else                               cnt_d = cnt_q + ONE;
    end else begin
      cnt_d = cnt_q - ONE;
    end
    // Forward shadow next-state so a write in the boundary cycle is not lost.
    per_d    = load ? per_sh_d      : per_q;
    duty_d   = load ? duty_sh_d     : duty_q;
    center_d = load ? center_mode_i : center_q;
  end

  // Duty compare and tick; tick is delayed one extra cycle to line up with the
  // first output cycle of the new period.
  always_comb begin
    run = en_i && !per_zero;
    for (int i = 0; i < CH_NUM; i++) begin
      pwm_d[i] = (run && (cnt_q < duty_q[i])) ^ INV[i];
    end
    start_d = run && boundary;
    tick_d  = run && start_q;
  end

  // State registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      per_sh_q  <= PER_RST;
      per_q     <= PER_RST;
      duty_sh_q <= {CH_NUM{DUTY_RST}};
      duty_q    <= {CH_NUM{DUTY_RST}};
      center_q  <= 1'b0;
      cnt_q     <= '0;
      dir_q     <= DIR_UP;
      pwm_q     <= INV;
      start_q   <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      per_sh_q  <= per_sh_d;
      per_q     <= per_d;
      duty_sh_q <= duty_sh_d;
      duty_q    <= duty_d;
      center_q  <= center_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      pwm_q     <= pwm_d;
      start_q   <= start_d;
      tick_q    <= tick_d;
    end
  end

  assign pwm_out_o     = pwm_q;
  assign period_tick_o = tick_q;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Bench for pwm_multi_ch: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a phase-position model.
module tb_pwm_multi_ch;

  localparam int         CH    = 4;
  localparam logic [3:0] INV_P = 4'b0010;

  logic        sys_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic        en = 1'b0, center_mode = 1'b0, cfg_we = 1'b0;
  logic [3:0]  cfg_addr = 4'd0;
  logic [15:0] cfg_wdata = 16'd0;
  logic [3:0]  pwm_out;
  logic        period_tick;

  int n_chk = 0;
  int n_pass = 0;

  pwm_multi_ch #(.CH_NUM(CH), .CNT_W(16), .PERIOD_DEF(50000), .DUTY_DEF(30000),
                 .INV(INV_P)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .en_i(en), .center_mode_i(center_mode),
    .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
    .pwm_out_o(pwm_out), .period_tick_o(period_tick));

  always #5 sys_clk = ~sys_clk;

  // Reference model: position t within the current period (length P or 2P),
  // counter value derived arithmetically from t.
  int unsigned m_per = 50000, m_sh_per = 50000;
  int unsigned m_duty[CH] = '{default: 30000};
  int unsigned m_sh_duty[CH] = '{default: 30000};
  bit          m_center = 0;
  int unsigned m_t = 0;
  bit          m_wrapped = 0;
  logic [3:0]  exp_out = INV_P;
  logic        exp_tick = 1'b0;
  int unsigned m_len, m_c;
  bit          m_load;

  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_per = 50000; m_sh_per = 50000; m_center = 0; m_t = 0; m_wrapped = 0;
      for (int i = 0; i < CH; i++) begin m_duty[i] = 30000; m_sh_duty[i] = 30000; end
      exp_out = INV_P; exp_tick = 1'b0;
    end else begin
      m_load = 0;
      if (!en || m_per == 0) begin
        exp_out = INV_P; exp_tick = 1'b0; m_t = 0; m_wrapped = 0; m_load = 1;
      end else begin
        m_len = m_center ? 2 * m_per : m_per;
        m_c   = (m_t < m_per) ? m_t : m_len - 1 - m_t;
        for (int i = 0; i < CH; i++) exp_out[i] = (m_c < m_duty[i]) ^ INV_P[i];
        exp_tick  = m_wrapped;
        m_wrapped = (m_t == m_len - 1);
        if (m_t == m_len - 1) begin m_t = 0; m_load = 1; end
        else m_t = m_t + 1;
      end
      if (cfg_we) begin
        if (cfg_addr == 0) m_sh_per = cfg_wdata;
        else if (cfg_addr <= CH) m_sh_duty[cfg_addr-1] = cfg_wdata;
      end
      if (m_load) begin
        m_per = m_sh_per; m_center = center_mode;
        for (int i = 0; i < CH; i++) m_duty[i] = m_sh_duty[i];
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge sys_clk) begin
    n_chk++;
    if (pwm_out === exp_out && period_tick === exp_tick) n_pass++;
    else $display("FAIL model_cmp t=%0t: pwm_out=%b tick=%b, expected pwm_out=%b tick=%b",
                  $time, pwm_out, period_tick, exp_out, exp_tick);
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge sys_clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_tick(input string nm, input int budget);
    int n;
    n = 0;
    do begin @(negedge sys_clk); n++; end while (period_tick !== 1'b1 && n < budget);
    chk(nm, int'(period_tick === 1'b1), 1);
  endtask

  function automatic logic [3:0] raw();
    return pwm_out ^ INV_P;
  endfunction

  initial begin
    int ones, ticks, h, g;
    logic [15:0] pat;

    repeat (3) @(negedge sys_clk);
    chk("reset_pwm", int'(pwm_out), int'(INV_P));
    chk("reset_tick", int'(period_tick), 0);
    rst_n = 1'b1;
    @(negedge sys_clk);
    chk("post_reset_pwm", int'(pwm_out), 2);

    // Defaults: 30000 high of 50000; mid-period writes stay in shadow.
    en = 1'b1;
    ones = 0; ticks = 0;
    for (int n = 1; n <= 50000; n++) begin
      @(negedge sys_clk);
      ones += int'(raw()[0]);
      ticks += int'(period_tick);
      if (n == 25000) begin cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 16'd10; end
      if (n == 25001) begin cfg_addr = 4'd2; cfg_wdata = 16'd3; end
      if (n == 25002) cfg_we = 1'b0;
    end
    chk("t1_ch0_high", ones, 30000);
    chk("t1_no_early_tick", ticks, 0);
    @(negedge sys_clk);
    chk("t1_tick_at_50001", int'(period_tick), 1);
    h = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge sys_clk);
      h += int'(raw()[1]);
    end
    @(negedge sys_clk);
    chk("t2_tick_interval_10", int'(period_tick), 1);
    chk("t2_ch1_high", h, 3);

    // Duty 0 / P / >P across wraps.
    wr(4'd1, 16'd0); wr(4'd2, 16'd10); wr(4'd3, 16'd15);
    wait_tick("t3_tick_a", 40); wait_tick("t3_tick_b", 40);
    ones = 0; h = 0; g = 0;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) @(negedge sys_clk);
      ones += int'(raw()[0]); h += int'(raw()[1]); g += int'(raw()[2]);
    end
    chk("t3_ch0_zero", ones, 0);
    chk("t3_ch1_full", h, 30);
    chk("t3_ch2_full", g, 30);

    // Center mode P=8 duty=3: 16-cycle symmetric pattern.
    center_mode = 1'b1;
    wr(4'd0, 16'd8); wr(4'd1, 16'd3);
    wait_tick("t4_tick_a", 60); wait_tick("t4_tick_b", 60);
    pat = '0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge sys_clk);
      pat[k] = raw()[0];
    end
    chk("t4_pattern", int'(pat), 16'hE007);
    @(negedge sys_clk);
    chk("t4_tick_interval_16", int'(period_tick), 1);

    // en drop mid-period, then restart from cnt 0.
    repeat (5) @(negedge sys_clk);
    en = 1'b0;
    @(negedge sys_clk);
    chk("t5_idle_pwm", int'(pwm_out), 2);
    ticks = 0;
    repeat (20) begin @(negedge sys_clk); ticks += int'(period_tick); end
    chk("t5_idle_no_tick", ticks, 0);
    en = 1'b1;
    h = 0;
    do begin
      @(negedge sys_clk); h++;
      if (h == 1) chk("t5_restart_cnt0", int'(raw()[0]), 1);
    end while (period_tick !== 1'b1 && h < 100);
    chk("t5_first_tick_at_17", h, 17);

    // Write in the boundary cycle takes effect in the very next period.
    center_mode = 1'b0;
    wr(4'd0, 16'd10);
    wait_tick("t6_tick_a", 60); wait_tick("t6_tick_b", 60);
    g = 0;
    while (m_t != 9 && g < 40) begin @(negedge sys_clk); g++; end
    wr(4'd1, 16'd5);
    @(negedge sys_clk);
    chk("t6_tick", int'(period_tick), 1);
    h = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge sys_clk);
      h += int'(raw()[0]);
    end
    chk("t6_ch0_high_5", h, 5);
    @(negedge sys_clk);
    #2 rst_n = 1'b0;
    #1 chk("t6_async_rst_pwm", int'(pwm_out), 2);
    chk("t6_async_rst_tick", int'(period_tick), 0);
    @(negedge sys_clk);
    rst_n = 1'b1;

    // Randomized phase, checked by the model compare only.
    en = 1'b0;
    wr(4'd0, 16'd9);
    en = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      cfg_we    = ($urandom_range(0, 3) == 0);
      cfg_addr  = 4'($urandom_range(0, 7));
      cfg_wdata = 16'($urandom_range(0, 12));
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 29) == 0) center_mode = ~center_mode;
      @(negedge sys_clk);
    end
    cfg_we = 1'b0;
    repeat (5) @(negedge sys_clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog");
  end

endmodule
